constraint_sampler_ctrl: RTL and testbench

- Sequencer that drives a combinational constraint-checker module (many packed input variables, single satisfied flag `x`).
- Generates pseudo-random candidate vectors from a seeded LFSR and presents each to the checker.
- Retries until the checker reports satisfied or an attempt budget is exhausted.
- Returns accepted samples over a valid/ready handshake; sits between the test harness and the generated checker.

---
 rtl/constraint_sampler_ctrl_if.sv | 51 +++++
 rtl/constraint_sampler_ctrl.sv | 161 ++++++++++++++++
 tb/tb_constraint_sampler_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/constraint_sampler_ctrl_if.sv
// Bundle between the constraint sampler, its checker and the consuming harness.
// Latency: none, this is wiring only; all timing is set by the sampler.
// Backpressure: out_valid/out_ready on the sample path; optional stats under SAMPLER_STATS_EN.
interface constraint_sampler_ctrl_if #(
  parameter int VEC_W     = 220,
  parameter int MAX_TRIES = 1024
);
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  logic               start;
  logic               seed_load;
  logic [31:0]        seed;
  logic [VEC_W-1:0]   cand_o;
  logic               sat_i;
  logic               out_valid;
  logic               out_ready;
  logic [VEC_W-1:0]   sample_o;
  logic               busy;
  logic               fail;
  logic [TRIES_W-1:0] tries_o;

`ifdef SAMPLER_STATS_EN
  logic [31:0]        accept_cnt;
  logic [31:0]        attempt_cnt;

  // Sampler side: consumes control and checker verdict, produces candidates and samples.
  modport master (
    input  start, seed_load, seed, sat_i, out_ready,
    output cand_o, out_valid, sample_o, busy, fail, tries_o, accept_cnt, attempt_cnt
  );

  // Harness/checker side: the mirror image.
  modport slave (
    output start, seed_load, seed, sat_i, out_ready,
    input  cand_o, out_valid, sample_o, busy, fail, tries_o, accept_cnt, attempt_cnt
  );
`else
  // Sampler side: consumes control and checker verdict, produces candidates and samples.
  modport master (
    input  start, seed_load, seed, sat_i, out_ready,
    output cand_o, out_valid, sample_o, busy, fail, tries_o
  );

  // Harness/checker side: the mirror image.
  modport slave (
    output start, seed_load, seed, sat_i, out_ready,
    input  cand_o, out_valid, sample_o, busy, fail, tries_o
  );
`endif

endinterface

// File: rtl/constraint_sampler_ctrl.sv
// Rejection sampler: fills a candidate from a 32-bit Galois LFSR, checks it, retries up to MAX_TRIES.
// Latency: WORDS fill cycles + 1 check cycle per attempt; sample valid the cycle after a passing check.
// Backpressure: accepted sample held in HOLD until out_ready; optional counters under SAMPLER_STATS_EN.
module constraint_sampler_ctrl #(
  parameter int          VEC_W     = 220,
  parameter int          MAX_TRIES = 1024,
  parameter logic [31:0] SEED      = 32'hACE1_0001
) (
  input  logic                      clk,
  input  logic                      rst,
  constraint_sampler_ctrl_if.master bus
);

  localparam int          WORDS   = (VEC_W + 31) / 32;
  localparam int          TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int          WC_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] TAPS    = 32'h8020_0003;

  localparam logic [WC_W-1:0]    LAST_WORD = WC_W'(WORDS - 1);
  localparam logic [TRIES_W-1:0] TRY_LIMIT = TRIES_W'(MAX_TRIES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;

  logic [2:0]         state;
  logic [31:0]        lfsr;
  logic [31:0]        lfsr_next;
  logic [VEC_W-1:0]   cand;
  logic [VEC_W-1:0]   cand_shifted;
  logic [VEC_W-1:0]   sample;
  logic [TRIES_W-1:0] tries;
  logic [TRIES_W-1:0] tries_inc;
  logic [WC_W-1:0]    word_cnt;
  logic               out_valid;
  logic               fail;
  logic               check_cycle;

  // Advance the Galois LFSR 32 single steps; one call produces a fresh 32-bit word.
  function automatic logic [31:0] lfsr_adv32(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < 32; i++) begin
      v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    end
    return v;
  endfunction

  assign lfsr_next   = lfsr_adv32(lfsr);
  assign tries_inc   = tries + 1'b1;
  assign check_cycle = (state == S_CHECK);

  // The newest LFSR word always lands in the low 32 bits; older words move up and fall off the top.
  generate
    if (VEC_W > 32) begin : g_shift
      assign cand_shifted = {cand[VEC_W-33:0], lfsr_next};
    end else begin : g_single
      assign cand_shifted = lfsr_next;
    end
  endgenerate

  // Main sequencer: seed/start handling, candidate fill, check verdict and sample hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      cand      <= '0;
      sample    <= '0;
      tries     <= '0;
      word_cnt  <= '0;
      out_valid <= 1'b0;
      fail      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FAIL: begin
          // A seed loaded together with start is the one the first fill steps from.
          if (bus.seed_load) begin
            lfsr <= (bus.seed == 32'd0) ? 32'd1 : bus.seed;
          end
          if (bus.start) begin
            tries    <= '0;
            fail     <= 1'b0;
            word_cnt <= '0;
            state    <= S_FILL;
          end
        end

        S_FILL: begin
          lfsr <= lfsr_next;
          cand <= cand_shifted;
          if (word_cnt == LAST_WORD) begin
            word_cnt <= '0;
            state    <= S_CHECK;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end

        S_CHECK: begin
          // cand has been stable for the whole cycle, so the checker output is settled here.
          tries <= tries_inc;
          if (bus.sat_i) begin
            sample    <= cand;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (tries_inc == TRY_LIMIT) begin
            fail  <= 1'b1;
            state <= S_FAIL;
          end else begin
            state <= S_FILL;
          end
        end

        S_HOLD: begin
          // out_valid is always high here; start and seed_load are deliberately not looked at.
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SAMPLER_STATS_EN
  logic [31:0] accept_cnt;
  logic [31:0] attempt_cnt;

  // Lifetime counters: cleared only by rst, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt  <= '0;
      attempt_cnt <= '0;
    end else if (check_cycle) begin
      if (attempt_cnt != 32'hFFFF_FFFF) begin
        attempt_cnt <= attempt_cnt + 32'd1;
      end
      if (bus.sat_i && (accept_cnt != 32'hFFFF_FFFF)) begin
        accept_cnt <= accept_cnt + 32'd1;
      end
    end
  end

  assign bus.accept_cnt  = accept_cnt;
  assign bus.attempt_cnt = attempt_cnt;
`endif

  assign bus.cand_o    = cand;
  assign bus.sample_o  = sample;
  assign bus.out_valid = out_valid;
  assign bus.fail      = fail;
  assign bus.tries_o   = tries;
  assign bus.busy      = (state == S_FILL) || check_cycle;

endmodule

// File: tb/tb_constraint_sampler_ctrl.sv
// Randomized bench for constraint_sampler_ctrl with VEC_W=64, MAX_TRIES=4 against a run-level model.
// Latency: expectations are expressed per attempt (WORDS fill cycles then one check cycle).
// Backpressure: out_ready is withheld for random spans while start/seed_load are pulsed in HOLD.
module tb_constraint_sampler_ctrl;

  localparam int          VW     = 64;
  localparam int          MT     = 4;
  localparam int          WORDS  = 2;
  localparam logic [31:0] SEED_P = 32'hACE1_0001;
  localparam logic [31:0] TAPS   = 32'h8020_0003;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  constraint_sampler_ctrl_if #(.VEC_W(VW), .MAX_TRIES(MT)) bus ();

  constraint_sampler_ctrl #(
    .VEC_W    (VW),
    .MAX_TRIES(MT),
    .SEED     (SEED_P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: LFSR word source, candidate contents, sticky fail flag, lifetime stats.
  logic [31:0] m_lfsr;
  logic [63:0] m_cand;
  logic        m_fail;
  longint      exp_acc;
  longint      exp_att;
  logic [63:0] s_por;
  logic [63:0] s_tmp;
  logic [63:0] exp_s1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference word generator: 32 iterations of the Galois rule x -> (x>>1) ^ (lsb ? taps : 0).
  function automatic logic [31:0] next_word(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    for (int i = 0; i < 32; i++) v = (v >> 1) ^ ({32{v[0]}} & TAPS);
    return v;
  endfunction

  task automatic model_reset();
    m_lfsr  = SEED_P;
    m_cand  = 64'd0;
    m_fail  = 1'b0;
    exp_acc = 0;
    exp_att = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start     = 1'b0;
      bus.seed_load = 1'b0;
      bus.sat_i     = 1'($urandom);
      bus.out_ready = 1'($urandom);
      check("idle_busy", 64'(bus.busy), 64'd0);
      check("idle_valid", 64'(bus.out_valid), 64'd0);
      check("idle_fail", 64'(bus.fail), 64'(m_fail));
    end
  endtask

  // One run: succ_at = attempt number whose check passes (0 = never, run must fail).
  task automatic do_run(input bit do_seed, input logic [31:0] sd, input int succ_at,
                        input int ready_delay, input bit noise, output logic [63:0] smp);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.seed_load = do_seed;
    bus.seed      = sd;
    bus.sat_i     = noise ? 1'($urandom) : 1'b0;
    if (do_seed) m_lfsr = (sd == 32'd0) ? 32'd1 : sd;
    m_fail = 1'b0;
    for (int a = 1; a <= MT && !ok; a++) begin
      for (int w = 0; w < WORDS; w++) begin
        @(negedge clk);
        bus.start     = noise ? 1'($urandom) : 1'b0;
        bus.seed_load = noise ? 1'($urandom) : 1'b0;
        bus.seed      = $urandom;
        bus.sat_i     = noise ? 1'($urandom) : 1'b0;
        bus.out_ready = noise ? 1'($urandom) : 1'b0;
        check("fill_busy", 64'(bus.busy), 64'd1);
        check("fill_valid", 64'(bus.out_valid), 64'd0);
        check("fill_fail", 64'(bus.fail), 64'd0);
        check("fill_tries", 64'(bus.tries_o), 64'(a - 1));
        m_lfsr = next_word(m_lfsr);
        m_cand = (m_cand << 32) | 64'(m_lfsr);
      end
      @(negedge clk);
      check("chk_busy", 64'(bus.busy), 64'd1);
      check("chk_cand", 64'(bus.cand_o), m_cand);
      check("chk_tries", 64'(bus.tries_o), 64'(a - 1));
      bus.sat_i = (a == succ_at);
      exp_att++;
      if (a == succ_at) begin
        ok = 1'b1;
        exp_acc++;
      end
    end
    @(negedge clk);
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    bus.out_ready = 1'b0;
    bus.sat_i     = noise ? 1'($urandom) : 1'b0;
    if (ok) begin
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_sample", 64'(bus.sample_o), m_cand);
      check("hold_busy", 64'(bus.busy), 64'd0);
      check("hold_fail", 64'(bus.fail), 64'd0);
      check("hold_tries", 64'(bus.tries_o), 64'(succ_at));
      for (int d = 0; d < ready_delay; d++) begin
        bus.start     = noise ? 1'($urandom) : 1'b0;
        bus.seed_load = noise ? 1'($urandom) : 1'b0;
        bus.seed      = $urandom;
        @(negedge clk);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_sample", 64'(bus.sample_o), m_cand);
        check("stall_busy", 64'(bus.busy), 64'd0);
      end
      bus.start     = 1'b0;
      bus.seed_load = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("done_valid", 64'(bus.out_valid), 64'd0);
      check("done_busy", 64'(bus.busy), 64'd0);
      check("done_sample", 64'(bus.sample_o), m_cand);
    end else begin
      m_fail = 1'b1;
      check("fail_flag", 64'(bus.fail), 64'd1);
      check("fail_tries", 64'(bus.tries_o), 64'(MT));
      check("fail_valid", 64'(bus.out_valid), 64'd0);
      check("fail_busy", 64'(bus.busy), 64'd0);
    end
    smp = m_cand;
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed      = 32'd0;
    bus.sat_i     = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state after five idle cycles.
    idle(5);
    check("rst_tries", 64'(bus.tries_o), 64'd0);
    check("rst_cand", 64'(bus.cand_o), 64'd0);
    check("rst_sample", 64'(bus.sample_o), 64'd0);

    // First-attempt success straight from the power-on seed.
    do_run(1'b0, 32'd0, 1, 0, 1'b0, s_por);

    // Exhausted budget, then a new start clears fail.
    do_run(1'b0, 32'd0, 0, 0, 1'b0, s_tmp);
    idle(2);
    do_run(1'b0, 32'd0, 2, 3, 1'b1, s_tmp);

    // Long stall in HOLD with start/seed_load pulses that must be ignored.
    do_run(1'b0, 32'd0, 1, 10, 1'b1, s_tmp);

    // Seed 1, seed 1 again, seed 0 (mapped to 1): identical samples.
    exp_s1 = {next_word(32'd1), next_word(next_word(32'd1))};
    do_run(1'b1, 32'd1, 1, 0, 1'b0, s_tmp);
    check("seed1_a", 64'(bus.sample_o), exp_s1);
    do_run(1'b1, 32'd1, 1, 1, 1'b0, s_tmp);
    check("seed1_b", 64'(bus.sample_o), exp_s1);
    do_run(1'b1, 32'd0, 1, 2, 1'b0, s_tmp);
    check("seed0", 64'(bus.sample_o), exp_s1);

    // Reset during the second fill cycle, then a fresh run repeats the power-on sample.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_tries", 64'(bus.tries_o), 64'd0);
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_cand", 64'(bus.cand_o), 64'd0);
    do_run(1'b0, 32'd0, 1, 0, 1'b0, s_tmp);
    check("por_repeat", 64'(bus.sample_o), s_por);

    // Random runs: random seeding (sometimes zero), pass point, stall length and input noise.
    for (int r = 0; r < 25; r++) begin
      logic [31:0] sd;
      sd = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      do_run(1'($urandom_range(0, 1)), sd, $urandom_range(0, MT),
             $urandom_range(0, 4), 1'b1, s_tmp);
      idle($urandom_range(0, 3));
    end

`ifdef SAMPLER_STATS_EN
    check("stat_accept", 64'(bus.accept_cnt), 64'(exp_acc));
    check("stat_attempt", 64'(bus.attempt_cnt), 64'(exp_att));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
